cache_line_writeback: RTL and testbench

- Reads one 256-bit line from the cache data array (the array's outData) and streams it to the memory side as 32-bit beats over a valid/ready handshake.
- Used on eviction of a dirty line. Sits between the cache data array and the memory write port, driven by the cache controller's start/done pair.
- Snapshots the line on start, so the array may be refilled while the writeback is still in progress.

---
 rtl/cache_line_writeback_if.sv | 37 +++
 rtl/cache_line_writeback.sv | 120 ++++++++++++
 tb/tb_cache_line_writeback.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_writeback_if.sv
// Memory-side write beat channel for the cache line writeback engine.
// WB_PARITY_EN adds a per-byte even-parity field aligned with memData.
interface cache_line_writeback_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BEAT_W = 32
);
  logic              memValid;
  logic              memReady;
  logic [ADDR_W-1:0] memAddr;
  logic [BEAT_W-1:0] memData;
  logic              memLast;
`ifdef WB_PARITY_EN
  logic [BEAT_W/8-1:0] memParity;
`endif

  modport master (
    output memValid,
    input  memReady,
    output memAddr,
    output memData,
`ifdef WB_PARITY_EN
    output memParity,
`endif
    output memLast
  );

  modport slave (
    input  memValid,
    output memReady,
    input  memAddr,
    input  memData,
`ifdef WB_PARITY_EN
    input  memParity,
`endif
    input  memLast
  );
endinterface

// File: rtl/cache_line_writeback.sv
// Snapshots one cache line on start and streams it out as valid/ready beats.
// Optional macro WB_PARITY_EN drives per-byte even parity on the beat channel.
module cache_line_writeback #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     lineAddr,
  input  logic [LINE_W-1:0]     lineData,
  output logic                  busy,
  output logic                  done,
  cache_line_writeback_if.master mem
);

  localparam int unsigned BEATS      = LINE_W / BEAT_W;
  localparam int unsigned BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LINE_BYTES = LINE_W / 8;
  localparam logic [ADDR_W-1:0]     ADDR_MASK  = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0]     BEAT_BYTES = ADDR_W'(BEAT_W / 8);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT  = BEAT_IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                state;
  logic [BEAT_IDX_W-1:0] beat;
  logic [LINE_W-1:0]     shadow;

  logic [BEAT_IDX_W-1:0] beatSel;
  logic [LINE_W-1:0]     srcLine;
  logic [BEAT_W-1:0]     nextData;

  // Beat that will be presented after the coming edge: beat 0 of the incoming
  // line on accept, otherwise the successor of the beat currently on the bus.
  always_comb begin
    beatSel  = (state == StIdle) ? '0 : beat + 1'b1;
    srcLine  = (state == StIdle) ? lineData : shadow;
    nextData = srcLine[beatSel*BEAT_W +: BEAT_W];
  end

`ifdef WB_PARITY_EN
  function automatic logic [BEAT_W/8-1:0] byteParity(input logic [BEAT_W-1:0] d);
    logic [BEAT_W/8-1:0] p;
    p = '0;
    for (int i = 0; i < int'(BEAT_W / 8); i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= StIdle;
      beat         <= '0;
      shadow       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem.memValid <= 1'b0;
      mem.memLast  <= 1'b0;
      mem.memAddr  <= '0;
      mem.memData  <= '0;
`ifdef WB_PARITY_EN
      mem.memParity <= '0;
`endif
    end else begin
      case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state        <= StSend;
            shadow       <= lineData;
            beat         <= '0;
            busy         <= 1'b1;
            mem.memValid <= 1'b1;
            mem.memData  <= nextData;
            mem.memAddr  <= lineAddr & ADDR_MASK;
            mem.memLast  <= (beatSel == LAST_BEAT);
`ifdef WB_PARITY_EN
            mem.memParity <= byteParity(nextData);
`endif
          end
        end
        StSend: begin
          // memValid is always high here, so memReady alone marks a handshake.
          if (mem.memReady) begin
            if (beat == LAST_BEAT) begin
              state        <= StDone;
              done         <= 1'b1;
              mem.memValid <= 1'b0;
              mem.memLast  <= 1'b0;
              mem.memData  <= '0;
              mem.memAddr  <= '0;
`ifdef WB_PARITY_EN
              mem.memParity <= '0;
`endif
            end else begin
              beat        <= beatSel;
              mem.memData <= nextData;
              mem.memAddr <= mem.memAddr + BEAT_BYTES;
              mem.memLast <= (beatSel == LAST_BEAT);
`ifdef WB_PARITY_EN
              mem.memParity <= byteParity(nextData);
`endif
            end
          end
        end
        StDone: begin
          state <= StIdle;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_writeback.sv
// Directed self-checking bench for cache_line_writeback (8 x 32-bit beats).
module tb_cache_line_writeback;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  lineAddr;
  logic [255:0] lineData;
  logic         busy;
  logic         done;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  cache_line_writeback_if #(.ADDR_W(32), .BEAT_W(32)) memIf ();

  cache_line_writeback #(
    .LINE_W(256),
    .BEAT_W(32),
    .ADDR_W(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .lineAddr (lineAddr),
    .lineData (lineData),
    .busy     (busy),
    .done     (done),
    .mem      (memIf)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] countLine();
    logic [255:0] l;
    for (int i = 0; i < 32; i++) l[8*i +: 8] = 8'(i);
    return l;
  endfunction

  function automatic logic [31:0] beatOf(input int k);
    return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
  endfunction

  // Counts edges until done is seen; an expired bound shows up as a wrong count.
  task automatic waitDone(input string tag, input int expTicks);
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    checkVal(tag, 64'(n), 64'(expTicks));
  endtask

  initial begin
    bit sawDone;
    reset          = 1'b0;
    start          = 1'b1;
    lineAddr       = 32'h0000_1047;
    lineData       = countLine();
    memIf.memReady = 1'b1;

    // Reset dominates start.
    tick();
    tick();
    checkVal("rst busy",  64'(busy), 64'd0);
    checkVal("rst done",  64'(done), 64'd0);
    checkVal("rst valid", 64'(memIf.memValid), 64'd0);
    checkVal("rst last",  64'(memIf.memLast), 64'd0);
    checkVal("rst addr",  64'(memIf.memAddr), 64'd0);
    checkVal("rst data",  64'(memIf.memData), 64'd0);
`ifdef WB_PARITY_EN
    checkVal("rst parity", 64'(memIf.memParity), 64'd0);
`endif
    reset = 1'b1;
    start = 1'b0;
    tick();
    checkVal("idle valid", 64'(memIf.memValid), 64'd0);

    // Basic stream with memReady tied high.
    start = 1'b1;
    tick();
    start = 1'b0;
    checkVal("basic beat0 data", 64'(memIf.memData), 64'h0302_0100);
    checkVal("basic beat0 addr", 64'(memIf.memAddr), 64'h0000_1040);
    for (int k = 0; k < 8; k++) begin
      checkVal($sformatf("basic b%0d data", k), 64'(memIf.memData), 64'(beatOf(k)));
      checkVal($sformatf("basic b%0d addr", k), 64'(memIf.memAddr), 64'(32'h1040 + 4*k));
      checkVal($sformatf("basic b%0d last", k), 64'(memIf.memLast), 64'(k == 7));
      checkVal($sformatf("basic b%0d valid", k), 64'(memIf.memValid), 64'd1);
      checkVal($sformatf("basic b%0d done", k), 64'(done), 64'd0);
      checkVal($sformatf("basic b%0d busy", k), 64'(busy), 64'd1);
      tick();
    end
    checkVal("basic done", 64'(done), 64'd1);
    checkVal("basic done busy", 64'(busy), 64'd1);
    checkVal("basic done valid", 64'(memIf.memValid), 64'd0);
    checkVal("basic done last", 64'(memIf.memLast), 64'd0);
    tick();
    checkVal("basic idle done", 64'(done), 64'd0);
    checkVal("basic idle busy", 64'(busy), 64'd0);

    // Backpressure on beat2.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    memIf.memReady = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      checkVal($sformatf("bp hold%0d data", r), 64'(memIf.memData), 64'h0B0A_0908);
      checkVal($sformatf("bp hold%0d addr", r), 64'(memIf.memAddr), 64'h0000_1048);
      checkVal($sformatf("bp hold%0d valid", r), 64'(memIf.memValid), 64'd1);
    end
    memIf.memReady = 1'b1;
    waitDone("bp done latency", 6);
    tick();

    // Snapshot: line changes and a stray start during SEND are ignored.
    start = 1'b1;
    tick();
    start    = 1'b0;
    lineData = '1;
    lineAddr = 32'hDEAD_0000;
    for (int k = 0; k < 8; k++) begin
      checkVal($sformatf("snap b%0d data", k), 64'(memIf.memData), 64'(beatOf(k)));
      checkVal($sformatf("snap b%0d busy", k), 64'(busy), 64'd1);
      if (k == 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    checkVal("snap done", 64'(done), 64'd1);
    checkVal("snap done busy", 64'(busy), 64'd1);
    start    = 1'b1;
    lineData = countLine();
    lineAddr = 32'h0000_3000;
    tick();
    checkVal("start in done ignored valid", 64'(memIf.memValid), 64'd0);
    checkVal("start in done ignored busy", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    checkVal("restart valid", 64'(memIf.memValid), 64'd1);
    checkVal("restart addr", 64'(memIf.memAddr), 64'h0000_3000);
    checkVal("restart busy", 64'(busy), 64'd1);

    // Reset after beat4 is accepted abandons the line.
    for (int k = 0; k < 5; k++) tick();
    checkVal("pre-reset addr", 64'(memIf.memAddr), 64'h0000_3014);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkVal("midrst valid", 64'(memIf.memValid), 64'd0);
    checkVal("midrst busy", 64'(busy), 64'd0);
    checkVal("midrst done", 64'(done), 64'd0);
    checkVal("midrst addr", 64'(memIf.memAddr), 64'd0);
    sawDone = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    checkVal("midrst no done", 64'(sawDone), 64'd0);
    lineAddr = 32'h0000_2000;
    start    = 1'b1;
    tick();
    start = 1'b0;
    checkVal("post-rst beat0 addr", 64'(memIf.memAddr), 64'h0000_2000);
    checkVal("post-rst beat0 data", 64'(memIf.memData), 64'h0302_0100);
    checkVal("post-rst valid", 64'(memIf.memValid), 64'd1);
    waitDone("post-rst done latency", 8);
    tick();

`ifdef WB_PARITY_EN
    checkVal("idle parity", 64'(memIf.memParity), 64'd0);
    lineData         = countLine();
    lineData[31:0]   = 32'hFF07_0301;
    start            = 1'b1;
    tick();
    start = 1'b0;
    checkVal("parity beat0", 64'(memIf.memParity), 64'b0101);
    tick();
    checkVal("parity beat1", 64'(memIf.memParity), 64'b1001);
    waitDone("parity done latency", 7);
    checkVal("parity in done", 64'(memIf.memParity), 64'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
